// File: rtl/mips_pkg.sv
// Shared MIPS register-file types and widths used by the write-back arbiter.
package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO: storage, pointers, occupancy and per-entry live bits,
// with a kill port that cancels entries made stale by a newer pipeline write.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enq_en,
  input  wb_req_t                             enq_req,
  input  logic                                deq_en,
  input  logic                                kill_en,
  input  logic [REG_ADDR_W-1:0]               kill_addr,
  output logic                                full,
  output logic                                empty,
  output wb_req_t                             head,
  output logic                                head_live,
  output logic [DEPTH-1:0]                    live,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    addrs
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_req_t          r_mem [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // NOTE: payload storage has no reset; the live bits and pointers are reset,
  // so stale payload can never be written back.
  always_ff @(posedge clk) begin
    if (enq_en) r_mem[r_wr_ptr] <= enq_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_live   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && r_mem[i].addr == kill_addr) r_live[i] <= 1'b0;
      end
      if (deq_en) begin
        r_live[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + 1'b1;
      end
      // A load killed in its own enqueue cycle is stored already dead.
      if (enq_en) begin
        r_live[r_wr_ptr] <= !(kill_en && kill_addr == enq_req.addr);
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      case ({enq_en, deq_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    full      = (r_count == CNT_W'(DEPTH));
    empty     = (r_count == '0);
    head      = r_mem[r_rd_ptr];
    head_live = r_live[r_rd_ptr];
    live      = r_live;
    for (int i = 0; i < DEPTH; i++) addrs[i] = r_mem[i].addr;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: the pipeline always wins, load results
// queue in wb_fifo and drain into idle slots; exports a pending-register mask.
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0]     pipe_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0]     lsu_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [NUM_REGS-1:0]   pending
);
  logic                               w_pipe_go;
  logic                               w_enq;
  logic                               w_deq;
  logic                               w_full;
  logic                               w_empty;
  wb_req_t                            w_head;
  logic                               w_head_live;
  logic [DEPTH-1:0]                   w_live;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]   w_addrs;
  logic [NUM_REGS-1:0]                w_pending;

  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0]     r_rf_wdata;

  // Writes to r0 are architectural no-ops: they neither claim the port nor queue.
  assign w_pipe_go = pipe_we && (pipe_addr != '0);
  assign lsu_ready = !w_full;
  assign w_enq     = lsu_valid && lsu_ready && (lsu_addr != '0);
  assign w_deq     = !w_pipe_go && !w_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .enq_en    (w_enq),
    .enq_req   ('{addr: lsu_addr, data: lsu_data}),
    .deq_en    (w_deq),
    .kill_en   (w_pipe_go),
    .kill_addr (pipe_addr),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head),
    .head_live (w_head_live),
    .live      (w_live),
    .addrs     (w_addrs)
  );

  // NOTE: always_comb gets a full default first so no path can infer a latch.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_live[i]) w_pending[w_addrs[i]] = 1'b1;
    end
    w_pending[0] = 1'b0;
  end
  assign pending = w_pending;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_wdata <= '0;
    end else if (w_pipe_go) begin
      r_rf_we    <= 1'b1;
      r_rf_addr  <= pipe_addr;
      r_rf_wdata <= pipe_data;
    end else if (w_deq && w_head_live) begin
      r_rf_we    <= 1'b1;
      r_rf_addr  <= w_head.addr;
      r_rf_wdata <= w_head.data;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_addr  = r_rf_addr;
  assign rf_wdata = r_rf_wdata;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_we   (pipe_we),
    .pipe_addr (pipe_addr),
    .pipe_data (pipe_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_addr  (lsu_addr),
    .lsu_data  (lsu_data),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        q[$];
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  bit          accepted;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] m = '0;
    foreach (q[i]) if (q[i].live && q[i].addr != 0) m[q[i].addr] = 1'b1;
    return m;
  endfunction

  // One clock: drive inputs after a falling edge, check state-derived outputs,
  // advance the model across the rising edge, then check the registered port.
  task automatic step(input bit r, input bit pw, input logic [4:0] pa, input logic [31:0] pd,
                      input bit lv, input logic [4:0] la, input logic [31:0] ld);
    bit ready, pipe_go;
    rst = r; pipe_we = pw; pipe_addr = pa; pipe_data = pd;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    #1;
    ready = (q.size() < DEPTH);
    check("lsu_ready", {31'd0, lsu_ready}, {31'd0, ready});
    check("pending", pending, model_pending());
    accepted = 1'b0;
    if (r) begin
      q.delete();
      exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    end else begin
      pipe_go  = pw && pa != 0;
      accepted = lv && ready;
      exp_we   = 1'b0;
      if (pipe_go) begin
        exp_we = 1'b1; exp_addr = pa; exp_data = pd;
        foreach (q[i]) if (q[i].addr == pa) q[i].live = 1'b0;
      end else if (q.size() > 0) begin
        ent_t h = q.pop_front();
        if (h.live) begin
          exp_we = 1'b1; exp_addr = h.addr; exp_data = h.data;
        end
      end
      if (accepted && la != 0) q.push_back('{addr: la, data: ld, live: !(pipe_go && pa == la)});
    end
    @(negedge clk);
    check("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
    check("rf_addr", {27'd0, rf_addr}, {27'd0, exp_addr});
    check("rf_wdata", rf_wdata, exp_data);
    check("rf_we_r0", {31'd0, rf_we && rf_addr == 0}, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int ld_idx;
    rst = 1'b1; pipe_we = 0; pipe_addr = 0; pipe_data = 0;
    lsu_valid = 0; lsu_addr = 0; lsu_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    q.delete(); exp_we = 0; exp_addr = 0; exp_data = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Pipeline priority: six pipe writes to r5 while four loads to r6 queue up.
    ld_idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(0, 1, 5'd5, 32'h11111111, ld_idx < 4, 5'd6, 32'hAAAA0001 + 32'(ld_idx));
      if (accepted) ld_idx++;
    end
    idle(6);

    // WAW kill: queue r7 behind a pipe write, kill it, then let the dead entry drain.
    step(0, 1, 5'd5, 32'h12345678, 1, 5'd7, 32'hDEAD0000);
    step(0, 1, 5'd7, 32'h00000007, 0, 0, 0);
    idle(3);
    // Kill of an entry enqueued in the same cycle.
    step(0, 1, 5'd9, 32'h99990000, 1, 5'd9, 32'hDEAD0009);
    idle(2);

    // Zero register on both producers; the load handshake still completes.
    step(0, 1, 5'd0, 32'hBAD00000, 1, 5'd0, 32'hBAD00001);
    step(0, 1, 5'd0, 32'hBAD00002, 1, 5'd3, 32'h33330003);
    idle(2);

    // Full boundary: fill under pipe pressure, then offer a load while draining.
    for (int c = 0; c < DEPTH; c++) step(0, 1, 5'd1, 32'h100 + 32'(c), 1, 5'd10 + 5'(c), 32'hF000 + 32'(c));
    step(0, 0, 0, 0, 1, 5'd20, 32'h20202020);
    step(0, 0, 0, 0, 1, 5'd20, 32'h20202020);
    idle(6);

    // Reset mid-operation with three entries in flight.
    for (int c = 0; c < 3; c++) step(0, 1, 5'd2, 32'h200 + 32'(c), 1, 5'd12 + 5'(c), 32'hE000 + 32'(c));
    step(1, 0, 0, 0, 0, 0, 0);
    idle(5);

    // Random traffic on a narrow address range to provoke collisions and kills.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom(),
           ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom());
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that owns the single write port of the 32x32 MIPS register file. It merges two producers: the in-order pipeline write-back stage and the long-latency load unit. The pipeline always wins the port; load results wait in a small FIFO and drain into idle slots. It also exports a pending-register mask so decode can stall on operands still in flight.

## Interface
Parameters:
- DEPTH, 4, load-result FIFO entries; power of two, ≥2

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pipe_we  in  1  pipeline write-back valid this cycle
- pipe_addr  in  5  pipeline destination register
- pipe_data  in  32  pipeline result
- lsu_valid  in  1  load unit offers a result
- lsu_ready  out  1  arbiter accepts load result this cycle
- lsu_addr  in  5  load destination register
- lsu_data  in  32  load result
- rf_we  out  1  register file write enable (drives WEx3)
- rf_addr  out  5  register file write address (drives A3)
- rf_wdata  out  32  register file write data (drives WDe3)
- pending  out  32  bit r set = live FIFO entry targets register r; bit 0 always 0

## Operation
- FIFO entry = {addr, data, live}. Count 0..DEPTH; read/write pointers wrap modulo DEPTH.
- lsu_ready = (count < DEPTH), combinational from registered count only; independent of lsu_valid and of a same-cycle dequeue.
- Enqueue on lsu_valid & lsu_ready. lsu_addr == 0: handshake completes, nothing enqueued.
- Grant each cycle, priority order:
  - pipe_we & pipe_addr != 0: pipeline slot; FIFO holds.
  - otherwise, FIFO non-empty: dequeue head; write it if live, else discard with no rf write.
  - otherwise: idle.
- pipe_we with pipe_addr == 0: treated as no pipeline write; FIFO may drain that cycle.
- WAW kill: a pipeline write to R (R != 0) clears live on every FIFO entry targeting R, including an entry enqueued in that same cycle. The pipeline result is the newer value; the load result is dropped.
- pending recomputed from registered FIFO state (OR over live entries), so it reflects state after the last edge.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Reset: count=0, pointers=0, all live=0, rf_we=0, rf_addr=0, rf_wdata=0, pending=0, lsu_ready=1. Entries in flight at reset are lost and produce no write.

## Timing
- rf_we/rf_addr/rf_wdata are registered.
- Pipeline write sampled at edge N drives rf_* during cycle N+1; the register file commits at edge N+2.
- Load accepted at edge N with an empty FIFO and no pipeline write at N+1: dequeued at edge N+1, on rf_* during N+1..N+2. Minimum load latency to rf_* is 2 cycles.
- Continuous pipeline writes starve the FIFO indefinitely. This is by design; the load unit sees lsu_ready low once the FIFO is full.
- A pending bit sets the cycle after enqueue and clears the cycle after dequeue or kill.

## Structure
- Shared package `mips_pkg`: REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, struct wb_req_t {addr, data}.
- Sub-module `wb_fifo`: storage, pointers, count, and live bits, with a kill_en/kill_addr port. The arbiter top adds grant logic, output registers, and pending OR-reduction.
- Estimated size: ~200 RTL lines.

## Test plan
- Reset mid-operation: fill 3 entries, assert rst for 1 cycle. Required: rf_we=0, pending=0, lsu_ready=1 next cycle, and no stale write afterward.
- Pipeline priority: pipe_we=1 on r5=0x11111111 for 6 cycles while loading r6=0xAAAA0001..r6=0xAAAA0004. Required: pipeline writes appear back-to-back; loads drain in order after the pipe stops; lsu_ready drops at count=4.
- WAW kill: enqueue r7=0xDEAD0000, then pipe writes r7=0x00000007 before the drain. Required: only 0x00000007 written to r7; dequeue cycle shows rf_we=0; pending[7] clears after the kill.
- Zero register: pipe_addr=0 and lsu_addr=0 writes. Required: rf_we never 1 with rf_addr=0; pending[0]=0; the load handshake completes.
- Full-boundary simultaneity: count=DEPTH, lsu_valid=1, FIFO draining. Required: lsu_ready=0 that cycle, count=DEPTH-1 after, and the load is accepted the next cycle.
